flash_mode_cmd: RTL and testbench
=================================

# flash_mode_cmd

In-band mode controller for the SPI flash RAID path; it sits directly upstream of the flash mux and drives its `sel0`/`sel1` inputs. The block snoops the host SPI bus in the system clock domain and decodes a vendor mode-select command (opcode plus one mode byte). Valid commands update the flash routing mode at the end of the transaction. Malformed commands are counted and otherwise ignored. The flashes ignore the unknown opcode, so the command is harmless on the wire.

## Interface
- `CMD_OPCODE`, 8'hA5, opcode identifying a mode-select transaction.
- `MAGIC`, 4'hC, required value of mode byte bits [7:4].

- `clk` input 1 system clock; must be at least 4x the `h_clk` frequency.
- `rst` input 1 reset. Asynchronous, active-high.
- `h_clk` input 1 host SPI clock, SPI mode 0, asynchronous to `clk`.
- `h_cs_n` input 1 host chip select, active low, asynchronous.
- `h_mosi` input 1 host MOSI, asynchronous.
- `sel0` output 1 Main Flash enable, to the mux.
- `sel1` output 1 Secondary Flash enable, to the mux.
- `cmd_ok` output 1 one-cycle pulse when a valid command is applied.
- `cmd_err` output 1 one-cycle pulse when a malformed command is rejected.
- `err_count` output 8 count of rejected commands; saturates at 255.
- `oneshot_active` output 1 high while a one-shot mode is in force.

## Operation
- **Input synchronisation:** `h_clk`, `h_cs_n` and `h_mosi` each pass through a 2-flop synchroniser.
  - An `h_clk` rising edge is detected on the synchronised signal.
  - `h_mosi` is sampled on that edge, MSB first.
- **Transaction FSM:**
  - WAIT_IDLE: entered from reset. Moves to IDLE once synchronised `h_cs_n` is 1, so a transaction already in flight at reset release is ignored.
  - IDLE: moves to SHIFT on a synchronised `h_cs_n` fall. The bit counter and shift register clear.
  - SHIFT: each `h_clk` rise shifts in one bit. The 5-bit bit counter saturates at 31. Bits 0-7 form the opcode byte; bits 8-15 form the mode byte.
  - SHIFT returns to IDLE on a synchronised `h_cs_n` rise, and the transaction is evaluated in that same cycle.
- **Evaluation:**
  - Opcode ≠ `CMD_OPCODE`, or fewer than 8 bits clocked: no command action (one-shot revert rule below still applies).
  - Opcode match with exactly 16 bits, mode[7:4] = `MAGIC` and mode[1:0] ≠ 2'b00: the command is valid.
    - Load {`sel1`,`sel0`} = mode[1:0].
    - Pulse `cmd_ok`.
  - Opcode match with any other bit count, a magic mismatch, or mode[1:0] = 00: reject.
    - Pulse `cmd_err` and increment `err_count`.
    - `sel0`/`sel1` are unchanged.
  - mode[2] is reserved and ignored.
- **Mode register:**
  - Persistent mode: {p1,p0}.
  - Outputs `sel0`/`sel1` are registered.
- **Reset values:** `sel0`=1, `sel1`=0 (MAIN); `cmd_ok`=0, `cmd_err`=0, `err_count`=0, `oneshot_active`=0; p = 2'b01 (p0=1, p1=0).
- **Reset mid-transaction:** all shifted bits are discarded and no pulse is produced.

## Timing
- Valid command: `sel0`/`sel1` and `cmd_ok` change on the 4th `clk` rising edge after `h_cs_n` rises at the pin.
  - This is 2 synchroniser cycles, 1 edge-detect cycle and 1 output-register cycle, within ±1 cycle of synchroniser uncertainty.
- `cmd_err` and the `err_count` update follow the same latency.
- The host must hold `h_cs_n` high for at least 6 `clk` cycles after a mode command. This guarantees the mux captures the new select before the next transaction.
- `cmd_ok` and `cmd_err` are never asserted in the same cycle.
- `sel0`/`sel1` never change while synchronised `h_cs_n` is 0.

## Configuration
- `FLASH_MODE_ONESHOT_EN` defined: mode[3]=1 makes the command one-shot.
  - The new mode is driven on `sel0`/`sel1` and `oneshot_active` is set. p is not updated.
  - At the end of the next transaction with ≥1 bit clocked, `sel0`/`sel1` revert to p and `oneshot_active` clears.
  - If that next transaction is itself a valid mode command, its result takes precedence over the revert.
  - If that next transaction is a rejected command, the revert still happens.
- `FLASH_MODE_ONESHOT_EN` undefined: mode[3] is ignored and every valid command is persistent. `oneshot_active` is tied to 0.

## Test plan
- Reset release with `h_cs_n`=1 → `sel0`=1, `sel1`=0, `err_count`=0. Send A5,C3 → `cmd_ok` pulse; `sel0`=1, `sel1`=1 four cycles after `h_cs_n` rises.
- Send A5,C2 then 03,00,00,00 (a read) → SHARE→SECONDARY (`sel0`=0, `sel1`=1). Mode is unchanged through the read and no pulses occur.
- Send A5,B1 (bad magic), A5,C0 (mode 00), and A5 plus 12 bits → three `cmd_err` pulses, `err_count`=3, `sel0`/`sel1` unchanged.
  - Force 260 rejects → `err_count` holds at 255.
- Assert `rst` after 11 bits of A5,C2, release with `h_cs_n` still low, then finish and deassert → no pulse and mode stays MAIN. A following A5,C2 is applied normally.
- With `FLASH_MODE_ONESHOT_EN` defined: A5,CA, then 03,00,00,00, then 05 (a status read).
  - After the first command: `oneshot_active`=1 and SECONDARY.
  - After the read: revert to MAIN and `oneshot_active`=0.
  - The 05 transaction sees MAIN.

Source files
------------

// File: rtl/flash_mode_cmd.sv
// rtl/flash_mode_cmd.sv - snooped SPI mode-select decoder driving the flash mux selects
// Optional one-shot mode commands enabled by defining FLASH_MODE_ONESHOT_EN.
module flash_mode_cmd #(
  parameter logic [7:0] CMD_OPCODE = 8'hA5,
  parameter logic [3:0] MAGIC      = 4'hC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       h_clk,
  input  logic       h_cs_n,
  input  logic       h_mosi,
  output logic       sel0,
  output logic       sel1,
  output logic       cmd_ok,
  output logic       cmd_err,
  output logic [7:0] err_count,
  output logic       oneshot_active
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  state_t state, state_next;

  // Stage [2] is the edge-detect register; the *_q flops hold its previous value.
  // Chip select resets to "busy" so WAIT_IDLE only sees a genuine idle bus.
  logic [2:0] clk_sr, cs_sr, mosi_sr;
  logic       clk_q, cs_q;
  logic       clk_rise, cs_d, mosi_d;

  logic [4:0] bit_cnt;
  logic [7:0] opcode, mode;
  logic       clr, shift, eval;
  logic       op_match, valid, reject;
  logic [1:0] sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sr  <= '0;
      cs_sr   <= '0;
      mosi_sr <= '0;
      clk_q   <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      clk_sr  <= {clk_sr[1:0], h_clk};
      cs_sr   <= {cs_sr[1:0], h_cs_n};
      mosi_sr <= {mosi_sr[1:0], h_mosi};
      clk_q   <= clk_sr[2];
      cs_q    <= cs_sr[2];
    end
  end

  assign clk_rise = clk_sr[2] & ~clk_q;
  assign cs_d     = cs_sr[2];
  assign mosi_d   = mosi_sr[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    clr        = 1'b0;
    shift      = 1'b0;
    eval       = 1'b0;
    case (state)
      WAIT_IDLE: if (cs_d) state_next = IDLE;
      IDLE: begin
        if (!cs_d && cs_q) begin
          state_next = SHIFT;
          clr        = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_d) begin
          state_next = IDLE;
          eval       = 1'b1;
        end else if (clk_rise) begin
          shift = 1'b1;
        end
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      opcode  <= '0;
      mode    <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
      opcode  <= '0;
      mode    <= '0;
    end else if (shift) begin
      if (bit_cnt < 5'd8)       opcode <= {opcode[6:0], mosi_d};
      else if (bit_cnt < 5'd16) mode   <= {mode[6:0], mosi_d};
      if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  assign op_match = (bit_cnt >= 5'd8) && (opcode == CMD_OPCODE);
  assign valid    = op_match && (bit_cnt == 5'd16) && (mode[7:4] == MAGIC) && (mode[1:0] != 2'b00);
  assign reject   = op_match && !valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ok    <= 1'b0;
      cmd_err   <= 1'b0;
      err_count <= '0;
    end else begin
      cmd_ok  <= eval && valid;
      cmd_err <= eval && reject;
      if (eval && reject && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

`ifdef FLASH_MODE_ONESHOT_EN
  logic [1:0] p;
  logic       oneshot_q;

  // A valid command wins over the pending revert; any other non-empty transaction reverts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= 2'b01;
      p         <= 2'b01;
      oneshot_q <= 1'b0;
    end else if (eval && valid) begin
      sel_q <= mode[1:0];
      if (mode[3]) begin
        oneshot_q <= 1'b1;
      end else begin
        p         <= mode[1:0];
        oneshot_q <= 1'b0;
      end
    end else if (eval && oneshot_q && bit_cnt != 5'd0) begin
      sel_q     <= p;
      oneshot_q <= 1'b0;
    end
  end

  assign oneshot_active = oneshot_q;

  logic unused_mode;
  assign unused_mode = mode[2];
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               sel_q <= 2'b01;
    else if (eval && valid) sel_q <= mode[1:0];
  end

  assign oneshot_active = 1'b0;

  logic unused_mode;
  assign unused_mode = ^mode[3:2];
`endif

  assign sel0 = sel_q[0];
  assign sel1 = sel_q[1];

endmodule

// File: tb/tb_flash_mode_cmd.sv
// tb/tb_flash_mode_cmd.sv - randomized scoreboard bench for flash_mode_cmd
// Reference model honours FLASH_MODE_ONESHOT_EN when defined for the build.
`timescale 1ns/1ps
module tb_flash_mode_cmd;

  localparam int HP = 41;

  logic       clk = 1'b0;
  logic       rst, h_clk, h_cs_n, h_mosi;
  logic       sel0, sel1, cmd_ok, cmd_err, oneshot_active;
  logic [7:0] err_count;

  flash_mode_cmd dut (
    .clk(clk), .rst(rst), .h_clk(h_clk), .h_cs_n(h_cs_n), .h_mosi(h_mosi),
    .sel0(sel0), .sel1(sel1), .cmd_ok(cmd_ok), .cmd_err(cmd_err),
    .err_count(err_count), .oneshot_active(oneshot_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         ok;
    logic [1:0] sel;
    int         err;
    bit         os;
  } exp_t;

  exp_t    sb[$];
  bit      tx[$];
  int      checks = 0;
  int      errors = 0;
  realtime t_rise = 0;

  logic [1:0] m_sel, m_p;
  bit         m_os;
  int         m_err;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel = 2'b01; m_p = 2'b01; m_os = 0; m_err = 0;
  endtask

  task automatic add_bits(input int val, input int n);
    for (int i = n - 1; i >= 0; i--) tx.push_back(bit'((val >> i) & 1));
  endtask

  // Behavioural decode of a whole transaction from the bit list.
  task automatic model_eval();
    int n;
    logic [7:0] opc, md;
    bit op_match, valid;
    exp_t e;
    n = tx.size();
    opc = '0; md = '0;
    for (int i = 0; i < 8 && i < n; i++) opc = {opc[6:0], tx[i]};
    for (int i = 8; i < 16 && i < n; i++) md = {md[6:0], tx[i]};
    op_match = (n >= 8) && (opc == 8'hA5);
    valid = op_match && (n == 16) && (md[7:4] == 4'hC) && (md[1:0] != 2'b00);
    if (valid) begin
      m_sel = md[1:0];
`ifdef FLASH_MODE_ONESHOT_EN
      if (md[3]) m_os = 1;
      else begin m_p = md[1:0]; m_os = 0; end
`else
      m_p = md[1:0];
`endif
    end else begin
      if (op_match && m_err < 255) m_err++;
      if (m_os && n > 0) begin m_sel = m_p; m_os = 0; end
    end
    if (valid || op_match) begin
      e.ok = valid; e.sel = m_sel; e.err = m_err; e.os = m_os;
      sb.push_back(e);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".sel0"}, sel0, m_sel[0]);
    chk({tag, ".sel1"}, sel1, m_sel[1]);
    chk({tag, ".err_count"}, err_count, m_err);
    chk({tag, ".oneshot"}, oneshot_active, m_os);
  endtask

  task automatic send_bit(input bit b);
    h_mosi = b;
    #HP h_clk = 1'b1;
    #HP h_clk = 1'b0;
  endtask

  task automatic run_xfer(input string tag);
    h_cs_n = 1'b0;
    #HP;
    foreach (tx[i]) send_bit(tx[i]);
    #HP;
    model_eval();
    h_cs_n = 1'b1;
    t_rise = $realtime;
    #200;
    check_state(tag);
    tx.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_ok && cmd_err) chk("ok_err_exclusive", 1, 0);
      if (cmd_ok || cmd_err) begin
        if (sb.size() == 0) begin
          chk("spurious_pulse", 1, 0);
        end else begin
          exp_t e;
          realtime d;
          e = sb.pop_front();
          d = $realtime - t_rise;
          chk("pulse_kind_ok", cmd_ok, e.ok);
          chk("pulse_sel", {sel1, sel0}, e.sel);
          chk("pulse_err_count", err_count, e.err);
          chk("pulse_oneshot", oneshot_active, e.os);
          chk("pulse_latency_in_window", (d >= 25 && d <= 55) ? 1 : 0, 1);
        end
      end
    end
  end

  initial begin
    int r, n;
    rst = 1'b1; h_clk = 1'b0; h_cs_n = 1'b1; h_mosi = 1'b0;
    model_reset();
    #53;
    check_state("reset");
    chk("reset.cmd_ok", cmd_ok, 0);
    chk("reset.cmd_err", cmd_err, 0);
    rst = 1'b0;
    #100;
    check_state("post_reset");

    add_bits(8'hA5, 8); add_bits(8'hC3, 8); run_xfer("a5c3");
    add_bits(8'hA5, 8); add_bits(8'hC2, 8); run_xfer("a5c2");
    add_bits(32'h03000000, 32); run_xfer("read");
    add_bits(8'hA5, 8); add_bits(8'hB1, 8); run_xfer("bad_magic");
    add_bits(8'hA5, 8); add_bits(8'hC0, 8); run_xfer("mode00");
    add_bits(8'hA5, 8); add_bits(12'h3C1, 12); run_xfer("len20");
    chk("three_rejects", m_err, 3);

    // Reset partway through A5,C2, released while chip select is still low.
    add_bits(8'hA5, 8); add_bits(8'hC2, 8);
    h_cs_n = 1'b0;
    #HP;
    for (int i = 0; i < 11; i++) send_bit(tx[i]);
    rst = 1'b1; #27; rst = 1'b0;
    model_reset();
    for (int i = 11; i < 16; i++) send_bit(tx[i]);
    #HP h_cs_n = 1'b1;
    #200;
    check_state("mid_reset");
    tx.delete();
    add_bits(8'hA5, 8); add_bits(8'hC2, 8); run_xfer("after_reset");

    add_bits(8'hA5, 8); add_bits(8'hC1, 8); run_xfer("back_main");
    add_bits(8'hA5, 8); add_bits(8'hCA, 8); run_xfer("oneshot_cmd");
    add_bits(32'h03000000, 32); run_xfer("oneshot_read");
    add_bits(8'h05, 8); run_xfer("status_read");

    for (int k = 0; k < 260; k++) begin
      add_bits(8'hA5, 8); run_xfer("sat");
    end
    chk("err_saturated", err_count, 255);

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: begin add_bits(8'hA5, 8); add_bits({4'hC, 2'($urandom), 2'($urandom_range(1, 3))}, 8); end
        1: begin add_bits(8'hA5, 8); add_bits(8'($urandom), 8); end
        2: begin add_bits(8'hA5, 8); add_bits({4'hC, 2'($urandom), 2'b00}, 8); end
        3: begin add_bits(8'hA5, 8); n = $urandom_range(0, 24); add_bits(int'($urandom), n); end
        4: begin n = $urandom_range(0, 32); add_bits(int'($urandom), n); end
        default: begin n = $urandom_range(0, 7); add_bits(int'($urandom), n); end
      endcase
      run_xfer("random");
    end

    #200;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
